// File: rtl/arf_rat.sv
// arf_rat: architectural register file plus register alias table, fed by ROB retire and dispatch rename
// Ports: clk/rst (async active-high reset); retire_* commits a ROB result into the ARF;
//   dispatch_* renames a destination to a ROB id on fire (valid & ready);
//   src1/src2 lookups return renamed flag, producing ROB id and ARF data combinationally;
//   fetch_redirect_valid_i drops every speculative mapping at the next edge.
// Build option: RETIRE_BYPASS_EN forwards a same-cycle retire to a matching lookup.
module arf_rat #(
  parameter int N_ARF    = 32,
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                retire_i,
  input  logic [ROB_ID_W-1:0] retire_rob_id_i,
  input  logic [4:0]          retire_arf_id_i,
  input  logic [XLEN-1:0]     retire_reg_data_i,
  input  logic                dispatch_valid_i,
  input  logic                dispatch_ready_i,
  input  logic                dispatch_dst_valid_i,
  input  logic [4:0]          dispatch_dst_arf_id_i,
  input  logic [ROB_ID_W-1:0] dispatch_rob_id_i,
  input  logic [4:0]          src1_arf_id_i,
  input  logic [4:0]          src2_arf_id_i,
  output logic                src1_renamed_o,
  output logic [ROB_ID_W-1:0] src1_rob_id_o,
  output logic [XLEN-1:0]     src1_data_o,
  output logic                src2_renamed_o,
  output logic [ROB_ID_W-1:0] src2_rob_id_o,
  output logic [XLEN-1:0]     src2_data_o,
  input  logic                fetch_redirect_valid_i
);
  logic [XLEN-1:0]     arf_q [N_ARF];
  logic [XLEN-1:0]     arf_d [N_ARF];
  logic [N_ARF-1:0]    rat_valid_q, rat_valid_d;
  logic [ROB_ID_W-1:0] rat_rob_q [N_ARF];
  logic [ROB_ID_W-1:0] rat_rob_d [N_ARF];
  logic                ren [2];
  logic [ROB_ID_W-1:0] rob [2];
  logic [XLEN-1:0]     dat [2];
  logic [4:0]          sid;
  logic                fire;

  assign fire = dispatch_valid_i & dispatch_ready_i & dispatch_dst_valid_i & (dispatch_dst_arf_id_i != 5'd0);

  // Retire clears a mapping only if it still names the retiring ROB id; dispatch is applied
  // afterwards so a same-cycle rename of the same register wins, and a redirect overrides both.
  always_comb begin
    arf_d       = arf_q;
    rat_valid_d = rat_valid_q;
    rat_rob_d   = rat_rob_q;
    if (retire_i && retire_arf_id_i != 5'd0) begin
      arf_d[retire_arf_id_i] = retire_reg_data_i;
      if (rat_valid_q[retire_arf_id_i] && rat_rob_q[retire_arf_id_i] == retire_rob_id_i)
        rat_valid_d[retire_arf_id_i] = 1'b0;
    end
    if (fetch_redirect_valid_i) rat_valid_d = '0;
    else if (fire) begin
      rat_valid_d[dispatch_dst_arf_id_i] = 1'b1;
      rat_rob_d[dispatch_dst_arf_id_i]   = dispatch_rob_id_i;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arf_q       <= '{default: '0};
      rat_valid_q <= '0;
      rat_rob_q   <= '{default: '0};
    end else begin
      arf_q       <= arf_d;
      rat_valid_q <= rat_valid_d;
      rat_rob_q   <= rat_rob_d;
    end

  // x0 is never written, so its ARF slot stays zero and only the renamed flag needs masking.
  always_comb begin
    sid = 5'd0;
    for (int s = 0; s < 2; s++) begin
      sid    = (s == 1) ? src2_arf_id_i : src1_arf_id_i;
      ren[s] = (sid != 5'd0) && rat_valid_q[sid];
      rob[s] = rat_rob_q[sid];
      dat[s] = arf_q[sid];
`ifdef RETIRE_BYPASS_EN
      if (ren[s] && retire_i && retire_arf_id_i == sid && retire_rob_id_i == rat_rob_q[sid]) begin
        ren[s] = 1'b0;
        dat[s] = retire_reg_data_i;
      end
`endif
    end
  end

  assign src1_renamed_o = ren[0];
  assign src1_rob_id_o  = rob[0];
  assign src1_data_o    = dat[0];
  assign src2_renamed_o = ren[1];
  assign src2_rob_id_o  = rob[1];
  assign src2_data_o    = dat[1];
endmodule

// File: tb/tb_arf_rat.sv
// tb_arf_rat: randomized and directed checks of arf_rat against an array-based reference model
module tb_arf_rat;
  logic        clk = 0, rst = 0;
  logic        retire = 0, dv = 0, dr = 0, ddv = 0, redirect = 0;
  logic [3:0]  rrob = 0, drob = 0;
  logic [4:0]  raid = 0, dd = 0, s1 = 0, s2 = 0;
  logic [31:0] rdata = 0;
  logic        r1, r2;
  logic [3:0]  id1, id2;
  logic [31:0] d1, d2;
  int          checks = 0, failures = 0;
  logic [31:0] m_arf [32];
  logic        m_v [32];
  logic [3:0]  m_rob [32];

  arf_rat dut (
    .clk(clk), .rst(rst),
    .retire_i(retire), .retire_rob_id_i(rrob), .retire_arf_id_i(raid), .retire_reg_data_i(rdata),
    .dispatch_valid_i(dv), .dispatch_ready_i(dr), .dispatch_dst_valid_i(ddv),
    .dispatch_dst_arf_id_i(dd), .dispatch_rob_id_i(drob),
    .src1_arf_id_i(s1), .src2_arf_id_i(s2),
    .src1_renamed_o(r1), .src1_rob_id_o(id1), .src1_data_o(d1),
    .src2_renamed_o(r2), .src2_rob_id_o(id2), .src2_data_o(d2),
    .fetch_redirect_valid_i(redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      m_arf[i] = 0; m_v[i] = 0; m_rob[i] = 0;
    end
  endtask

  task automatic idle();
    retire = 0; dv = 0; dr = 0; ddv = 0; redirect = 0;
  endtask

  task automatic expect_src(input logic [4:0] s, output logic er, output logic [3:0] eid, output logic [31:0] ed);
    er  = s != 0 && m_v[s];
    eid = m_rob[s];
    ed  = s == 0 ? 32'h0 : m_arf[s];
`ifdef RETIRE_BYPASS_EN
    if (er && retire && raid == s && rrob == m_rob[s]) begin
      er = 0; ed = rdata;
    end
`endif
  endtask

  task automatic check_out();
    logic er; logic [3:0] eid; logic [31:0] ed;
    #1;
    expect_src(s1, er, eid, ed);
    chk("src1_renamed", 32'(r1), 32'(er));
    if (er) chk("src1_rob_id", 32'(id1), 32'(eid)); else chk("src1_data", d1, ed);
    expect_src(s2, er, eid, ed);
    chk("src2_renamed", 32'(r2), 32'(er));
    if (er) chk("src2_rob_id", 32'(id2), 32'(eid)); else chk("src2_data", d2, ed);
  endtask

  task automatic tick();
    check_out();
    @(posedge clk);
    if (retire && raid != 0) begin
      m_arf[raid] = rdata;
      if (m_v[raid] && m_rob[raid] == rrob) m_v[raid] = 0;
    end
    if (redirect) for (int i = 0; i < 32; i++) m_v[i] = 0;
    else if (dv && dr && ddv && dd != 0) begin
      m_v[dd] = 1; m_rob[dd] = drob;
    end
    @(negedge clk);
  endtask

  task automatic disp(input logic [4:0] a, input logic [3:0] r);
    dv = 1; dr = 1; ddv = 1; dd = a; drob = r;
  endtask

  task automatic ret(input logic [4:0] a, input logic [3:0] r, input logic [31:0] d);
    retire = 1; raid = a; rrob = r; rdata = d;
  endtask

  initial begin
    mreset();
    #1 rst = 1;
    @(negedge clk); @(negedge clk);
    s1 = 5; s2 = 3;
    #1;
    chk("reset_src1_renamed", 32'(r1), 0);
    chk("reset_x5_data", d1, 0);
    rst = 0;
    @(negedge clk);
    // dispatch then retire x3
    disp(3, 4); s1 = 3; tick();
    idle(); #1;
    chk("t2_renamed", 32'(r1), 1); chk("t2_rob_id", 32'(id1), 4);
    tick();
    ret(3, 4, 32'hDEAD); tick();
    idle(); #1;
    chk("t2_retired_renamed", 32'(r1), 0); chk("t2_retired_data", d1, 32'hDEAD);
    tick();
    // younger mapping survives an older retire
    disp(3, 4); tick();
    disp(3, 7); tick();
    idle(); ret(3, 4, 32'h11); tick();
    idle(); #1;
    chk("t3_renamed", 32'(r1), 1); chk("t3_rob_id", 32'(id1), 7);
    tick();
    // same-cycle dispatch beats retire clear
    disp(3, 9); ret(3, 7, 32'h22); tick();
    idle(); #1;
    chk("t4_renamed", 32'(r1), 1); chk("t4_rob_id", 32'(id1), 9);
    redirect = 1; tick();
    idle(); #1;
    chk("t4_arf", d1, 32'h22);
    // flush with same-cycle dispatch and retire
    for (int i = 1; i <= 4; i++) begin
      disp(5'(i), 4'(i)); tick();
    end
    disp(6, 5); ret(1, 1, 32'h5); redirect = 1; tick();
    idle(); s1 = 1; s2 = 6; #1;
    chk("t5_x1_renamed", 32'(r1), 0); chk("t5_x1_data", d1, 32'h5); chk("t5_x6_renamed", 32'(r2), 0);
    for (int i = 2; i <= 4; i++) begin
      s1 = 5'(i); s2 = 5'(i + 1); tick();
      chk("t5_flushed", 32'(r1), 0);
    end
    // writes to x0 dropped
    ret(0, 0, 32'hFF); disp(0, 3); tick();
    idle(); s1 = 0; #1;
    chk("t6_x0_renamed", 32'(r1), 0); chk("t6_x0_data", d1, 0);
    // same-cycle retire of the current mapping
    disp(3, 7); s1 = 3; tick();
    idle(); ret(3, 7, 32'h33); #1;
`ifdef RETIRE_BYPASS_EN
    chk("byp_renamed", 32'(r1), 0); chk("byp_data", d1, 32'h33);
`else
    chk("nobyp_renamed", 32'(r1), 1); chk("nobyp_rob_id", 32'(id1), 7);
`endif
    tick();
    idle();
    // randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 7));
      retire   = 1'($urandom);
      raid     = r;
      rrob     = $urandom_range(0, 1) != 0 ? m_rob[r] : 4'($urandom);
      rdata    = $urandom;
      dv       = 1'($urandom); dr = $urandom_range(0, 3) != 0; ddv = $urandom_range(0, 3) != 0;
      dd       = $urandom_range(0, 7) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
      drob     = 4'($urandom);
      redirect = $urandom_range(0, 15) == 0;
      s1       = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
      s2       = 5'($urandom_range(0, 8));
      if (n == 300) begin
        #2 rst = 1;
        s1 = 5;
        #1;
        chk("midrst_src1_renamed", 32'(r1), 0); chk("midrst_src1_data", d1, 0);
        chk("midrst_src2_renamed", 32'(r2), 0); chk("midrst_src2_data", d2, 0);
        @(posedge clk); #1;
        chk("midrst_hold_renamed", 32'(r2), 0); chk("midrst_hold_data", d2, 0);
        @(negedge clk);
        mreset();
        rst = 0;
      end else tick();
    end
    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
